// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor, refclk domain.
// Holds the PLL in reset, waits for lock, filters lock for stability and then
// releases a registered downstream reset. Detects lock timeout (sticky flag,
// unlimited retries) and counts lock losses seen while running.
// Optional feature macro: PLL_AUTO_RELOCK_EN
//   defined     : a lock loss in RUN re-runs the PLL reset sequence automatically
//   not defined : a lock loss in RUN parks in FAULT until restart or rst_n
// The FSM state is exported on fsm_state for observation.
module pll_lock_supervisor #(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CW             = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       timeout,
  output logic [7:0] relock_cnt,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Terminal values of the shared counter for each timed state.
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          sync1;
  logic          lock_s;
  logic          timeout_d;
  logic          loss;
  logic [7:0]    relock_d;

  assign fsm_state = state;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  // Next-state, counter and sticky-flag logic; restart outranks lock events.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    timeout_d = timeout;
    loss      = 1'b0;
    if (restart && (state != HOLD)) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = HOLD;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        STABLE: begin
          // Any dropout restarts the stability filter from WAIT_LOCK.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            loss  = 1'b1;
            cnt_d = '0;
`ifdef PLL_AUTO_RELOCK_EN
            state_d = HOLD;
`else
            state_d = FAULT;
`endif
          end
        end
        FAULT: begin
          // Parked; only restart (above) or rst_n leaves this state.
          cnt_d = '0;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
    relock_d = (loss && (relock_cnt != 8'hFF)) ? relock_cnt + 8'd1 : relock_cnt;
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state      <= HOLD;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      timeout    <= 1'b0;
      relock_cnt <= 8'd0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pll_rst    <= (state_d == HOLD);
      ready      <= (state_d == RUN);
      sys_reset  <= (state_d != RUN);
      timeout    <= timeout_d;
      relock_cnt <= relock_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST_CYCLES=4, STABLE_CYCLES=8,
// TIMEOUT_CYCLES=32. Expected values are hand-derived cycle counts.
// Timing reference: after do_reset, tick(m) leaves the bench 1 time unit
// after edge t0+m-1, where it observes the values present at edge t0+m.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       timeout;
  logic [7:0] relock_cnt;
  logic [2:0] fsm_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(32),
    .CW            (17)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .ready     (ready),
    .timeout   (timeout),
    .relock_cnt(relock_cnt),
    .fsm_state (fsm_state)
  );

  // Clock generation.
  always #5 refclk = ~refclk;

  // Advance n rising edges and settle just past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // One comparison with failure accounting.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Full output check; sys_reset is always expected to be the inverse of ready.
  task automatic chk_out(input string tag, input logic e_pll_rst, input logic e_ready,
                         input logic e_timeout, input logic [7:0] e_relock);
    chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(e_pll_rst));
    chk({tag, ".ready"}, 32'(ready), 32'(e_ready));
    chk({tag, ".sys_reset"}, 32'(sys_reset), 32'(!e_ready));
    chk({tag, ".timeout"}, 32'(timeout), 32'(e_timeout));
    chk({tag, ".relock_cnt"}, 32'(relock_cnt), 32'(e_relock));
  endtask

  // Driver: hold rst_n low for three edges with the given lock level.
  task automatic do_reset(input logic lock);
    pll_locked = lock;
    restart    = 1'b0;
    rst_n      = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  initial begin
    // Test 1: locked throughout; pll_rst high t0..t0+3, ready from t0+13.
    do_reset(1'b1);
    chk_out("t1_reset", 1'b1, 1'b0, 1'b0, 8'd0);
    for (int m = 1; m <= 16; m++) begin
      tick(1);
      chk_out($sformatf("t1_m%0d", m), (m <= 3), (m >= 13), 1'b0, 8'd0);
    end

    // restart while in HOLD is ignored: timing identical to test 1.
    do_reset(1'b1);
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("hold_restart.pll_rst_m3", 32'(pll_rst), 32'd1);
    tick(1);
    chk("hold_restart.pll_rst_m4", 32'(pll_rst), 32'd0);
    tick(8);
    chk("hold_restart.ready_m12", 32'(ready), 32'd0);
    tick(1);
    chk("hold_restart.ready_m13", 32'(ready), 32'd1);

    // Test 2: one-cycle lock dropout during STABLE; release moves to t0+18.
    do_reset(1'b1);
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    for (int m = 8; m <= 19; m++) begin
      tick(1);
      chk_out($sformatf("t2_m%0d", m), 1'b0, (m >= 18), 1'b0, 8'd0);
    end

    // Test 3: never locks; timeout at t0+36, pll_rst pulses every 36 cycles.
    do_reset(1'b0);
    for (int m = 1; m <= 80; m++) begin
      tick(1);
      chk_out($sformatf("t3_m%0d", m), ((m % 36) < 4), 1'b0, (m >= 36), 8'd0);
    end
    // timeout stays set across a restart and a later successful lock.
    pll_locked = 1'b1;
    restart    = 1'b1;
    tick(1);
    restart = 1'b0;
    chk_out("t3_restart", 1'b1, 1'b0, 1'b1, 8'd0);
    tick(13);
    chk_out("t3_relocked", 1'b0, 1'b1, 1'b1, 8'd0);

    // Tests 4/5: lock loss in RUN.
    do_reset(1'b1);
    tick(13);
    chk_out("t45_run", 1'b0, 1'b1, 1'b0, 8'd0);
    pll_locked = 1'b0;
    tick(2);
    chk("t45_loss_e2.sys_reset", 32'(sys_reset), 32'd0);
    tick(1);
    pll_locked = 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
    chk_out("t4_e3", 1'b1, 1'b0, 1'b0, 8'd1);
    for (int k = 4; k <= 17; k++) begin
      tick(1);
      chk_out($sformatf("t4_e%0d", k), (k <= 6), (k >= 16), 1'b0, 8'd1);
    end
`else
    chk_out("t5_e3", 1'b0, 1'b0, 1'b0, 8'd1);
    for (int k = 4; k <= 10; k++) begin
      tick(1);
      chk_out($sformatf("t5_fault_e%0d", k), 1'b0, 1'b0, 1'b0, 8'd1);
    end
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk_out("t5_restart", 1'b1, 1'b0, 1'b0, 8'd1);
    for (int j = 1; j <= 14; j++) begin
      tick(1);
      chk_out($sformatf("t5_r%0d", j), (j <= 3), (j >= 13), 1'b0, 8'd1);
    end
`endif

    // Test 6: 300 losses in RUN saturate relock_cnt at 255.
    do_reset(1'b1);
    tick(13);
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back((i < 255) ? 8'(i + 1) : 8'd255);
      pll_locked = 1'b0;
      tick(3);
      pll_locked = 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
      tick(13);
`else
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      tick(13);
`endif
      chk($sformatf("t6_loss%0d.ready", i), 32'(ready), 32'd1);
      chk($sformatf("t6_loss%0d.relock_cnt", i), 32'(relock_cnt), 32'(exp_q.pop_front()));
    end
    // restart in RUN drops ready but leaves relock_cnt saturated.
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk_out("t6_restart", 1'b1, 1'b0, 1'b0, 8'd255);
    tick(13);
    chk_out("t6_rerun", 1'b0, 1'b1, 1'b0, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
